// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto one shared line-wide memory port.
// Ties go to D; defining ARB_ROUND_ROBIN_EN makes them alternate between sides.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic              busy,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RECOVER = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'((LINE_W / 8) - 1);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [LINE_W-1:0]   r_wdata;
  logic                r_is_write;
  logic                w_i_req;
  logic                w_d_req;
  logic                w_d_wins_tie;
  logic                w_grant_i;
  logic                w_grant_d;

  // Handshake: a requester holds its request level until its x_resp pulse;
  // mem_resp is a one-cycle completion that closes the outstanding command.
  assign w_i_req = i_read;
  assign w_d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_d <= 1'b0;
    end else if (w_grant_d) begin
      r_last_d <= 1'b1;
    end else if (w_grant_i) begin
      r_last_d <= 1'b0;
    end
  end

  assign w_d_wins_tie = ~r_last_d;
`else
  assign w_d_wins_tie = 1'b1;
`endif

  assign w_grant_d = (r_state == IDLE) && w_d_req && (!w_i_req || w_d_wins_tie);
  assign w_grant_i = (r_state == IDLE) && w_i_req && !w_grant_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    i_resp    = 1'b0;
    d_resp    = 1'b0;
    i_rdata   = '0;
    d_rdata   = '0;
    case (r_state)
      IDLE: begin
        if (w_grant_d) begin
          w_next = SERVE_D;
        end else if (w_grant_i) begin
          w_next = SERVE_I;
        end
      end
      SERVE_I: begin
        mem_read = 1'b1;
        if (mem_resp) begin
          i_resp  = 1'b1;
          i_rdata = mem_rdata;
          w_next  = RECOVER;
        end
      end
      SERVE_D: begin
        mem_read  = ~r_is_write;
        mem_write = r_is_write;
        if (mem_resp) begin
          d_resp  = 1'b1;
          d_rdata = mem_rdata;
          w_next  = RECOVER;
        end
      end
      RECOVER: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Transaction context is captured only on the granting edge, so requester
  // inputs are free to move while the shared port is busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_is_write <= 1'b0;
    end else if (w_grant_d) begin
      r_addr     <= d_addr;
      r_wdata    <= d_wdata;
      r_is_write <= d_write;
    end else if (w_grant_i) begin
      r_addr     <= i_addr;
      r_wdata    <= '0;
      r_is_write <= 1'b0;
    end
  end

  assign mem_addr    = r_addr & ~LINE_MASK;
  assign mem_wdata   = r_wdata;
  assign busy        = (r_state != IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a line-granular memory/arbitration reference model.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;
  localparam int CW = 1 + AW + LW;
  localparam int RW = 1 + LW;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_addr;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_resp;
  logic          busy;
  logic [1:0]    o_dbg_state;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .busy(busy), .o_dbg_state(o_dbg_state)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  logic [CW-1:0] cmd_q[$];
  logic [RW-1:0] resp_q[$];
  logic [LW-1:0] ref_mem[logic [AW-1:0]];
  logic [LW-1:0] mem_store[logic [AW-1:0]];
  bit            last_d;
  int            next_lat;
  int            stray_seq;
  int            stray_done;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [LW-1:0] init_line(input logic [AW-1:0] a);
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = a ^ (32'h5EED_0000 + 32'(k));
    return v;
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    return AW'($urandom_range(0, 15)) * 32'd32 + AW'($urandom_range(0, 31));
  endfunction

  // Reference model: line address, memory contents and arbitration history.
  function automatic void expect_txn(input bit side_d, input bit is_wr, input logic [AW-1:0] addr,
                                     input logic [LW-1:0] wdata, input bit with_resp);
    logic [AW-1:0] line;
    logic [LW-1:0] rd;
    line = (addr / AW'(LW / 8)) * AW'(LW / 8);
    if (is_wr) begin
      ref_mem[line] = wdata;
      rd = '0;
    end else begin
      rd = ref_mem.exists(line) ? ref_mem[line] : init_line(line);
    end
    cmd_q.push_back({is_wr, line, wdata});
    if (with_resp) resp_q.push_back({side_d, rd});
    last_d = side_d;
  endfunction

  // memory responder
  initial begin : responder
    int wait_cnt;
    mem_store[32'h0000_1220] = {32{8'hA5}};
    mem_resp   = 1'b0;
    mem_rdata  = '0;
    wait_cnt   = -1;
    stray_done = 0;
    forever begin
      @(posedge clk);
      #1;
      mem_resp  = 1'b0;
      mem_rdata = '0;
      if (!(mem_read || mem_write)) begin
        wait_cnt = -1;
        if (stray_done != stray_seq) begin
          stray_done = stray_seq;
          mem_resp   = 1'b1;
          mem_rdata  = rand_line();
        end
      end else begin
        if (wait_cnt < 0) wait_cnt = (next_lat >= 0) ? next_lat : int'($urandom_range(0, 4));
        if (wait_cnt == 0) begin
          mem_resp = 1'b1;
          wait_cnt = -1;
          if (mem_write) mem_store[mem_addr] = mem_wdata;
          else mem_rdata = mem_store.exists(mem_addr) ? mem_store[mem_addr] : init_line(mem_addr);
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // command monitor
  initial begin : cmd_mon
    logic          prev_act;
    logic          act;
    logic          have;
    logic [CW-1:0] cur;
    prev_act = 1'b0;
    have     = 1'b0;
    cur      = '0;
    forever begin
      @(negedge clk);
      act = mem_read | mem_write;
      check("cmd_exclusive", LW'(mem_read & mem_write), LW'(0));
      if (act && !prev_act) begin
        check("cmd_expected", LW'(cmd_q.size() != 0), LW'(1));
        if (cmd_q.size() != 0) begin
          cur  = cmd_q.pop_front();
          have = 1'b1;
        end
      end
      if (act && have) begin
        check("cmd_write", LW'(mem_write), LW'(cur[CW-1]));
        check("cmd_read", LW'(mem_read), LW'(!cur[CW-1]));
        check("cmd_addr", LW'(mem_addr), LW'(cur[CW-2 -: AW]));
        if (cur[CW-1]) check("cmd_wdata", mem_wdata, cur[LW-1:0]);
      end
      if (!act) have = 1'b0;
      prev_act = act;
    end
  end

  // response monitor
  initial begin : resp_mon
    logic [RW-1:0] e;
    forever begin
      @(negedge clk);
      check("dual_resp", LW'(i_resp & d_resp), LW'(0));
      if (!i_resp) check("i_rdata_zero", i_rdata, '0);
      if (!d_resp) check("d_rdata_zero", d_rdata, '0);
      if (i_resp || d_resp) begin
        check("resp_expected", LW'(resp_q.size() != 0), LW'(1));
        if (resp_q.size() != 0) begin
          e = resp_q.pop_front();
          check("resp_side", LW'(d_resp), LW'(e[RW-1]));
          check("resp_rdata", d_resp ? d_rdata : i_rdata, e[LW-1:0]);
        end
      end
    end
  end

  task automatic drop_inputs();
    i_read  = 1'b0;
    d_read  = 1'b0;
    d_write = 1'b0;
  endtask

  task automatic run_single(input bit side_d, input bit rd, input bit wr, input logic [AW-1:0] addr,
                            input logic [LW-1:0] wdata, input int lat, input bit scramble);
    int n_cmd;
    int guard;
    bit seen;
    @(posedge clk);
    #1;
    next_lat = lat;
    if (side_d) begin
      d_read = rd; d_write = wr; d_addr = addr; d_wdata = wdata;
    end else begin
      i_read = 1'b1; i_addr = addr;
    end
    expect_txn(side_d, side_d && wr, addr, wdata, 1'b1);
    if (scramble) begin
      @(posedge clk);
      #2;
      d_addr  = addr ^ 32'h0000_0300;
      d_wdata = ~wdata;
      i_addr  = addr ^ 32'h0000_0300;
    end
    n_cmd = 0;
    guard = 0;
    seen  = 1'b0;
    while (!seen && guard < 100) begin
      @(negedge clk);
      guard++;
      if (mem_read || mem_write) n_cmd++;
      seen = side_d ? d_resp : i_resp;
    end
    check("resp_timeout", LW'(seen), LW'(1));
    if (lat >= 0) check("cmd_cycles", LW'(n_cmd), LW'(lat + 1));
    @(posedge clk);
    #1;
    drop_inputs();
    @(negedge clk);
    check("recover_busy", LW'(busy), LW'(1));
    check("recover_no_resp", LW'(i_resp | d_resp), LW'(0));
    @(negedge clk);
    check("idle_busy", LW'(busy), LW'(0));
  endtask

  task automatic run_tie(input logic [AW-1:0] ia, input bit dr, input bit dw, input logic [AW-1:0] da,
                         input logic [LW-1:0] dwd);
    bit d_first;
    int got;
    int guard;
    d_first = !RR || !last_d;
    @(posedge clk);
    #1;
    next_lat = -1;
    i_read = 1'b1; i_addr = ia;
    d_read = dr; d_write = dw; d_addr = da; d_wdata = dwd;
    if (d_first) begin
      expect_txn(1'b1, dw, da, dwd, 1'b1);
      expect_txn(1'b0, 1'b0, ia, '0, 1'b1);
    end else begin
      expect_txn(1'b0, 1'b0, ia, '0, 1'b1);
      expect_txn(1'b1, dw, da, dwd, 1'b1);
    end
    got = 0;
    guard = 0;
    while (got < 2 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (d_resp) begin
        got++;
        @(posedge clk);
        #1;
        d_read = 1'b0; d_write = 1'b0;
      end else if (i_resp) begin
        got++;
        @(posedge clk);
        #1;
        i_read = 1'b0;
      end
    end
    check("tie_count", LW'(got), LW'(2));
    drop_inputs();
    repeat (2) @(posedge clk);
  endtask

  task automatic run_hold4(input logic [AW-1:0] ia, input logic [AW-1:0] da);
    int got;
    int guard;
    @(posedge clk);
    #1;
    next_lat = -1;
    for (int k = 0; k < 4; k++) begin
      if (!RR || !last_d) expect_txn(1'b1, 1'b0, da, '0, 1'b1);
      else expect_txn(1'b0, 1'b0, ia, '0, 1'b1);
    end
    i_read = 1'b1; i_addr = ia;
    d_read = 1'b1; d_write = 1'b0; d_addr = da;
    got = 0;
    guard = 0;
    while (got < 4 && guard < 300) begin
      @(negedge clk);
      guard++;
      if (i_resp || d_resp) got++;
    end
    check("hold4_count", LW'(got), LW'(4));
    @(posedge clk);
    #1;
    drop_inputs();
    repeat (2) @(posedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_i_rdata"}, i_rdata, '0);
    check({tag, "_i_resp"}, LW'(i_resp), LW'(0));
    check({tag, "_d_rdata"}, d_rdata, '0);
    check({tag, "_d_resp"}, LW'(d_resp), LW'(0));
    check({tag, "_mem_read"}, LW'(mem_read), LW'(0));
    check({tag, "_mem_write"}, LW'(mem_write), LW'(0));
    check({tag, "_mem_addr"}, LW'(mem_addr), LW'(0));
    check({tag, "_mem_wdata"}, mem_wdata, '0);
    check({tag, "_busy"}, LW'(busy), LW'(0));
    check({tag, "_state"}, LW'(o_dbg_state), LW'(0));
  endtask

  // main stimulus
  initial begin : main
    int            kind;
    int            op;
    logic [AW-1:0] a;
    rst = 1'b0;
    i_read = 1'b0; i_addr = '0;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
    next_lat  = -1;
    stray_seq = 0;
    last_d    = 1'b0;
    ref_mem[32'h0000_1220] = {32{8'hA5}};

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // I-side read, 3-cycle command, unaligned address
    run_single(1'b0, 1'b1, 1'b0, 32'h0000_1234, '0, 2, 1'b0);
    // D-side write
    run_single(1'b1, 1'b0, 1'b1, 32'h0000_0040, LW'(1), 1, 1'b0);
    // both sides held for four completions
    run_hold4(32'h0000_0800, 32'h0000_0900);

    // reset two cycles into SERVE_D, then a stray mem_resp
    @(posedge clk);
    #1;
    next_lat = 10;
    d_read = 1'b1; d_addr = 32'h0000_0300;
    expect_txn(1'b1, 1'b0, 32'h0000_0300, '0, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    check("pre_rst_mem_read", LW'(mem_read), LW'(1));
    rst = 1'b0;
    drop_inputs();
    #1;
    check_all_zero("midrst");
    last_d = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    stray_seq++;
    repeat (3) begin
      @(negedge clk);
      check("stray_no_resp", LW'(i_resp | d_resp), LW'(0));
    end

    // first tie after reset goes to D
    run_tie(32'h0000_0A00, 1'b1, 1'b0, 32'h0000_0B00, '0);
    // address changes while D is being served
    run_single(1'b1, 1'b1, 1'b0, 32'h0000_0100, '0, 3, 1'b1);
    // read and write together -> write
    run_single(1'b1, 1'b1, 1'b1, 32'h0000_0C20, rand_line(), 1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 3));
      op   = int'($urandom_range(0, 2));
      a    = rand_addr();
      case (kind)
        0: run_single(1'b0, 1'b1, 1'b0, a, '0, -1, $urandom_range(0, 1) == 1);
        1: run_single(1'b1, op != 1, op != 0, a, rand_line(), -1, $urandom_range(0, 1) == 1);
        2: run_single(1'b1, 1'b1, 1'b0, a, rand_line(), -1, 1'b0);
        default: run_tie(rand_addr(), op != 1, op != 0, a, rand_line());
      endcase
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (5) @(negedge clk);
    check("cmd_q_drained", LW'(cmd_q.size()), LW'(0));
    check("resp_q_drained", LW'(resp_q.size()), LW'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #400000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
